// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Registered branch resolution stage with flag register, 2-bit
//             BHT predictor and saturating branch/mispredict statistics.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int ADDR_W    = 32,
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              fzero_in,
    input  logic              fsign_in,
    input  logic              fcarry_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_branch,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              mispredict,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_taken,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam logic [5:0] c_OP_B    = 6'b101000;
    localparam logic [5:0] c_OP_BR   = 6'b100000;
    localparam logic [5:0] c_OP_BL   = 6'b101011;
    localparam logic [5:0] c_OP_BLTZ = 6'b110000;
    localparam logic [5:0] c_OP_BZ   = 6'b110001;
    localparam logic [5:0] c_OP_BNZ  = 6'b110010;
    localparam logic [5:0] c_OP_BCY  = 6'b101001;
    localparam logic [5:0] c_OP_BNCY = 6'b101010;

    localparam int                c_BHT_N   = 1 << BHT_IDX_W;
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_fzero;
    logic              r_fsign;
    logic              r_fcarry;
    logic              r_out_valid;
    logic              r_is_branch;
    logic              r_taken;
    logic [ADDR_W-1:0] r_next_pc;
    logic              r_mispredict;
    logic              r_link_we;
    logic [ADDR_W-1:0] r_link_data;
    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  r_mispred_count;
    logic [1:0]        r_bht [0:c_BHT_N-1];

    // ------------------------------------------------------------------
    // Combinational decode and resolution
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_fzero;
    logic                 w_fsign;
    logic                 w_fcarry;
    logic                 w_is_branch;
    logic                 w_is_cond;
    logic                 w_is_br;
    logic                 w_is_bl;
    logic                 w_taken;
    logic                 w_mispredict;
    logic [ADDR_W-1:0]    w_pc_plus4;
    logic [ADDR_W-1:0]    w_next_pc;
    logic [BHT_IDX_W-1:0] w_upd_idx;
    logic [BHT_IDX_W-1:0] w_lkp_idx;
    logic [1:0]           w_bht_cur;
    logic [1:0]           w_bht_nxt;
    logic                 w_unused_lookup;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A flag write in the same cycle as the branch is forwarded to it.
    assign w_fzero  = flag_we ? fzero_in  : r_fzero;
    assign w_fsign  = flag_we ? fsign_in  : r_fsign;
    assign w_fcarry = flag_we ? fcarry_in : r_fcarry;

    always_comb begin
        w_is_branch = 1'b0;
        w_is_cond   = 1'b0;
        w_is_br     = 1'b0;
        w_is_bl     = 1'b0;
        w_taken     = 1'b0;
        case (opcode)
            c_OP_B: begin
                w_is_branch = 1'b1;
                w_taken     = 1'b1;
            end
            c_OP_BR: begin
                w_is_branch = 1'b1;
                w_is_br     = 1'b1;
                w_taken     = 1'b1;
            end
            c_OP_BL: begin
                w_is_branch = 1'b1;
                w_is_bl     = 1'b1;
                w_taken     = 1'b1;
            end
            c_OP_BLTZ: begin
                w_is_branch = 1'b1;
                w_is_cond   = 1'b1;
                w_taken     = w_fsign;
            end
            c_OP_BZ: begin
                w_is_branch = 1'b1;
                w_is_cond   = 1'b1;
                w_taken     = w_fzero;
            end
            c_OP_BNZ: begin
                w_is_branch = 1'b1;
                w_is_cond   = 1'b1;
                w_taken     = !w_fzero;
            end
            c_OP_BCY: begin
                w_is_branch = 1'b1;
                w_is_cond   = 1'b1;
                w_taken     = w_fcarry;
            end
            c_OP_BNCY: begin
                w_is_branch = 1'b1;
                w_is_cond   = 1'b1;
                w_taken     = !w_fcarry;
            end
            default: begin
                w_is_branch = 1'b0;
            end
        endcase
    end

    assign w_pc_plus4   = pc + c_PC_STEP;
    assign w_next_pc    = w_taken ? (w_is_br ? rs_val : target) : w_pc_plus4;
    assign w_mispredict = (w_taken != pred_taken);

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    assign w_upd_idx = pc[BHT_IDX_W+1:2];
    assign w_lkp_idx = lookup_pc[BHT_IDX_W+1:2];
    assign w_bht_cur = r_bht[w_upd_idx];

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'b01;
        end
    end

    // Reads the registered array, so a same-cycle update is not visible yet.
    assign lookup_taken = r_bht[w_lkp_idx][1];

    assign w_unused_lookup = &{1'b0, lookup_pc[ADDR_W-1:BHT_IDX_W+2], lookup_pc[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_BHT_N; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && w_is_cond) begin
            r_bht[w_upd_idx] <= w_bht_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Flag register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fzero  <= 1'b0;
            r_fsign  <= 1'b0;
            r_fcarry <= 1'b0;
        end else if (flag_we) begin
            r_fzero  <= fzero_in;
            r_fsign  <= fsign_in;
            r_fcarry <= fcarry_in;
        end
    end

    // ------------------------------------------------------------------
    // Result pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_is_branch  <= 1'b0;
            r_taken      <= 1'b0;
            r_next_pc    <= '0;
            r_mispredict <= 1'b0;
            r_link_we    <= 1'b0;
            r_link_data  <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_is_branch  <= w_is_branch;
            r_taken      <= w_taken;
            r_next_pc    <= w_next_pc;
            r_mispredict <= w_mispredict;
            r_link_we    <= w_is_bl;
            r_link_data  <= w_is_bl ? w_pc_plus4 : '0;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else if (w_accept) begin
            if (w_is_branch && (r_branch_count != c_CNT_MAX)) begin
                r_branch_count <= r_branch_count + c_CNT_ONE;
            end
            if (w_mispredict && (r_mispred_count != c_CNT_MAX)) begin
                r_mispred_count <= r_mispred_count + c_CNT_ONE;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign is_branch     = r_is_branch;
    assign taken         = r_taken;
    assign next_pc       = r_next_pc;
    assign mispredict    = r_mispredict;
    assign link_we       = r_link_we;
    assign link_data     = r_link_data;
    assign branch_count  = r_branch_count;
    assign mispred_count = r_mispred_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Purpose  : Directed self-checking bench for branch_resolve_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst2 = 1'b0;
    logic        flag_we = 1'b0, fzero_in = 1'b0, fsign_in = 1'b0, fcarry_in = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, pred_taken = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] pc = '0, target = '0, rs_val = '0, lookup_pc = '0;

    logic        in_ready, out_valid, is_branch, taken, mispredict, link_we, lookup_taken;
    logic [31:0] next_pc, link_data;
    logic [15:0] branch_count, mispred_count;

    logic        in_ready2, out_valid2, is_branch2, taken2, mispredict2, link_we2, lookup_taken2;
    logic [31:0] next_pc2, link_data2;
    logic [1:0]  branch_count2, mispred_count2;

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(.ADDR_W(32), .BHT_IDX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .fzero_in(fzero_in), .fsign_in(fsign_in),
        .fcarry_in(fcarry_in), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .pc(pc), .target(target), .rs_val(rs_val), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .is_branch(is_branch), .taken(taken),
        .next_pc(next_pc), .mispredict(mispredict), .link_we(link_we), .link_data(link_data),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken), .branch_count(branch_count),
        .mispred_count(mispred_count)
    );

    branch_resolve_unit #(.ADDR_W(32), .BHT_IDX_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .flag_we(flag_we), .fzero_in(fzero_in), .fsign_in(fsign_in),
        .fcarry_in(fcarry_in), .in_valid(in_valid), .in_ready(in_ready2), .opcode(opcode),
        .pc(pc), .target(target), .rs_val(rs_val), .pred_taken(pred_taken),
        .out_valid(out_valid2), .out_ready(out_ready), .is_branch(is_branch2), .taken(taken2),
        .next_pc(next_pc2), .mispredict(mispredict2), .link_we(link_we2), .link_data(link_data2),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken2), .branch_count(branch_count2),
        .mispred_count(mispred_count2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_branch_count", 32'(branch_count), 32'd0);
        check("rst_mispred_count", 32'(mispred_count), 32'd0);
        check("rst_lookup_taken", 32'(lookup_taken), 32'd0);
        check("rst_next_pc", next_pc, 32'd0);
        rst = 1'b1;
        step();

        // bz with same-cycle flag write, predicted not taken
        in_valid = 1'b1; opcode = 6'b110001; flag_we = 1'b1; fzero_in = 1'b1;
        pc = 32'h20; target = 32'h80; pred_taken = 1'b0; lookup_pc = 32'h20;
        step();
        in_valid = 1'b0; flag_we = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_is_branch", 32'(is_branch), 32'd1);
        check("t1_taken", 32'(taken), 32'd1);
        check("t1_next_pc", next_pc, 32'h80);
        check("t1_mispredict", 32'(mispredict), 32'd1);
        check("t1_mispred_count", 32'(mispred_count), 32'd1);
        check("t1_branch_count", 32'(branch_count), 32'd1);
        check("t1_link_we", 32'(link_we), 32'd0);
        check("t1_bht_lookup", 32'(lookup_taken), 32'd1);
        step();
        check("t1_drain", 32'(out_valid), 32'd0);

        // br then bl back to back
        in_valid = 1'b1; opcode = 6'b100000; pc = 32'h30; rs_val = 32'h100;
        target = 32'h999; pred_taken = 1'b1; lookup_pc = 32'h30;
        step();
        check("t2_br_taken", 32'(taken), 32'd1);
        check("t2_br_next_pc", next_pc, 32'h100);
        check("t2_br_mispredict", 32'(mispredict), 32'd0);
        check("t2_br_link_data", link_data, 32'd0);
        opcode = 6'b101011; pc = 32'h40; target = 32'h200;
        step();
        check("t2_bl_link_we", 32'(link_we), 32'd1);
        check("t2_bl_link_data", link_data, 32'h44);
        check("t2_bl_next_pc", next_pc, 32'h200);
        check("t2_branch_count", 32'(branch_count), 32'd3);
        check("t2_uncond_no_bht", 32'(lookup_taken), 32'd0);

        // bcy four times at pc 0x10; lookup value is the one seen in the accept cycle
        opcode = 6'b101001; pc = 32'h10; target = 32'h400; pred_taken = 1'b1;
        lookup_pc = 32'h10; fcarry_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            flag_we = (i == 0);
            check($sformatf("t3_lookup_%0d", i), 32'(lookup_taken), (i == 0) ? 32'd0 : 32'd1);
            step();
            check($sformatf("t3_taken_%0d", i), 32'(taken), 32'd1);
        end
        flag_we = 1'b0;
        check("t3_lookup_final", 32'(lookup_taken), 32'd1);
        check("t3_branch_count", 32'(branch_count), 32'd7);

        // bnz with registered zero flag set -> not taken
        opcode = 6'b110010; pc = 32'h54; target = 32'h500; pred_taken = 1'b1;
        step();
        check("t3b_taken", 32'(taken), 32'd0);
        check("t3b_next_pc", next_pc, 32'h58);
        check("t3b_mispredict", 32'(mispredict), 32'd1);
        in_valid = 1'b0;
        step();

        // Back-pressure: hold result for three cycles
        out_ready = 1'b0; in_valid = 1'b1; opcode = 6'b110000; pc = 32'h60;
        target = 32'h600; pred_taken = 1'b0;
        step();
        check("t4_first_valid", 32'(out_valid), 32'd1);
        check("t4_first_next_pc", next_pc, 32'h64);
        opcode = 6'b101000; pc = 32'h70; target = 32'h300; pred_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_in_ready_%0d", i), 32'(in_ready), 32'd0);
            step();
            check($sformatf("t4_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("t4_hold_pc_%0d", i), next_pc, 32'h64);
            check($sformatf("t4_hold_taken_%0d", i), 32'(taken), 32'd0);
        end
        check("t4_stall_count", 32'(branch_count), 32'd9);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t4_second_pc", next_pc, 32'h300);
        check("t4_second_mispredict", 32'(mispredict), 32'd1);
        check("t4_branch_count", 32'(branch_count), 32'd10);
        step();
        check("t4_no_dup", 32'(out_valid), 32'd0);
        check("t4_mispred_count", 32'(mispred_count), 32'd3);

        // Non-branch at top of address space
        in_valid = 1'b1; opcode = 6'b000000; pc = 32'hFFFF_FFFC; pred_taken = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5_next_pc", next_pc, 32'h0);
        check("t5_is_branch", 32'(is_branch), 32'd0);
        check("t5_mispredict", 32'(mispredict), 32'd1);
        check("t5_branch_count", 32'(branch_count), 32'd10);
        check("t5_mispred_count", 32'(mispred_count), 32'd4);

        // Saturation on the narrow-counter instance, then reset mid-stall
        rst2 = 1'b1;
        step();
        in_valid = 1'b1; opcode = 6'b101000; pc = 32'h80; target = 32'h800; pred_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("t6_sat_mispred", 32'(mispred_count2), 32'd3);
        check("t6_sat_branch", 32'(branch_count2), 32'd3);
        check("t6_wide_mispred", 32'(mispred_count), 32'd9);
        out_ready = 1'b0; lookup_pc = 32'h10;
        step();
        check("t6_stalled", 32'(in_ready), 32'd0);
        check("t6_held_valid", 32'(out_valid), 32'd1);
        check("t6_bht_before", 32'(lookup_taken), 32'd1);
        rst = 1'b0; rst2 = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_valid2", 32'(out_valid2), 32'd0);
        check("t6_rst_branch", 32'(branch_count), 32'd0);
        check("t6_rst_mispred", 32'(mispred_count), 32'd0);
        check("t6_rst_mispred2", 32'(mispred_count2), 32'd0);
        check("t6_rst_bht", 32'(lookup_taken), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
